// File: rtl/sap1_sequencer_if.sv
// Bus between the SAP-1 sequencer and the datapath/front panel that drives it.
// The slave side is the sequencer; the master side supplies run/step, opcode and ALU status.
interface sap1_sequencer_if;
  logic        run;
  logic        step;
  logic [3:0]  opcode;
  logic        alu_zero;
  logic        alu_carry;
  logic [15:0] ctrl;
  logic [2:0]  step_count;
  logic        halted;
  logic        busy;

  modport slave (
    input  run, step, opcode, alu_zero, alu_carry,
    output ctrl, step_count, halted, busy
  );

  modport master (
    output run, step, opcode, alu_zero, alu_carry,
    input  ctrl, step_count, halted, busy
  );
endinterface

// File: rtl/sap1_sequencer.sv
// SAP-1 microcode sequencer: PAUSE/EXEC/HALT control with a T0..T5 micro-step counter
// and a combinational control-word decoder driven by opcode and latched ALU flags.
module sap1_sequencer (
  input  logic               clk,
  input  logic               reset,
  sap1_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Control word bit assignments.
  localparam logic [15:0] C_WRITE_OUT     = 16'h8000;
  localparam logic [15:0] C_SUBTRACT      = 16'h4000;
  localparam logic [15:0] C_MICRO_DONE    = 16'h2000;
  localparam logic [15:0] C_HALTED        = 16'h1000;
  localparam logic [15:0] C_INC_PC        = 16'h0800;
  localparam logic [15:0] C_WRITE_A       = 16'h0400;
  localparam logic [15:0] C_READ_A        = 16'h0200;
  localparam logic [15:0] C_WRITE_B       = 16'h0100;
  localparam logic [15:0] C_WRITE_PC      = 16'h0080;
  localparam logic [15:0] C_READ_PC       = 16'h0040;
  localparam logic [15:0] C_WRITE_INSTR   = 16'h0020;
  localparam logic [15:0] C_READ_INSTR    = 16'h0010;
  localparam logic [15:0] C_WRITE_MEM     = 16'h0008;
  localparam logic [15:0] C_READ_MEM      = 16'h0004;
  localparam logic [15:0] C_WRITE_MEM_ADR = 16'h0002;
  localparam logic [15:0] C_READ_ALU      = 16'h0001;

  localparam int unsigned BIT_MICRO_DONE = 13;
  localparam int unsigned BIT_HALTED     = 12;
  localparam int unsigned BIT_READ_ALU   = 0;

  localparam logic [2:0] LAST_STEP = 3'd5;

  // Shared microcode words.
  localparam logic [15:0] W_FETCH_ADR = C_READ_PC | C_WRITE_MEM_ADR;
  localparam logic [15:0] W_FETCH_IR  = C_INC_PC | C_READ_MEM | C_WRITE_INSTR;
  localparam logic [15:0] W_OPND_ADR  = C_READ_INSTR | C_WRITE_MEM_ADR;
  localparam logic [15:0] W_JUMP      = C_MICRO_DONE | C_WRITE_PC | C_READ_INSTR;

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic       free_run_q, free_run_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;
  logic [15:0] ctrl_w;

  function automatic logic [15:0] micro_word(
    input logic [2:0] t,
    input logic [3:0] op,
    input logic       carry,
    input logic       zero
  );
    logic [15:0] w;
    w = C_MICRO_DONE;
    case (t)
      3'd0: w = W_FETCH_ADR;
      3'd1: w = W_FETCH_IR;
      3'd2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: w = W_OPND_ADR;
          OP_LDI: w = C_MICRO_DONE | C_WRITE_A | C_READ_INSTR;
          OP_JMP: w = W_JUMP;
          OP_JC:  w = carry ? W_JUMP : C_MICRO_DONE;
          OP_JZ:  w = zero  ? W_JUMP : C_MICRO_DONE;
          OP_OUT: w = C_WRITE_OUT | C_MICRO_DONE | C_READ_A;
          OP_HLT: w = C_HALTED;
          default: w = C_MICRO_DONE;
        endcase
      end
      3'd3: begin
        case (op)
          OP_LDA:         w = C_MICRO_DONE | C_WRITE_A | C_READ_MEM;
          OP_ADD, OP_SUB: w = C_WRITE_B | C_READ_MEM;
          OP_STA:         w = C_MICRO_DONE | C_READ_A | C_WRITE_MEM;
          default:        w = C_MICRO_DONE;
        endcase
      end
      3'd4: begin
        case (op)
          OP_ADD:  w = C_MICRO_DONE | C_WRITE_A | C_READ_ALU;
          OP_SUB:  w = C_MICRO_DONE | C_SUBTRACT | C_WRITE_A | C_READ_ALU;
          default: w = C_MICRO_DONE;
        endcase
      end
      default: w = C_MICRO_DONE;
    endcase
    return w;
  endfunction

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    free_run_d = free_run_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    ctrl_w     = '0;

    case (state_q)
      ST_PAUSE: begin
        step_d = '0;
        if (bus.run) begin
          state_d    = ST_EXEC;
          free_run_d = 1'b1;
        end else if (bus.step) begin
          state_d    = ST_EXEC;
          free_run_d = 1'b0;
        end
      end

      ST_EXEC: begin
        ctrl_w = micro_word(step_q, bus.opcode, carry_q, zero_q);
        if (ctrl_w[BIT_READ_ALU]) begin
          carry_d = bus.alu_carry;
          zero_d  = bus.alu_zero;
        end
        if (ctrl_w[BIT_HALTED]) begin
          state_d = ST_HALT;
          step_d  = '0;
        end else if (ctrl_w[BIT_MICRO_DONE]) begin
          // The instruction always completes; run is only sampled at its boundary.
          step_d = '0;
          if (!(free_run_q && bus.run)) state_d = ST_PAUSE;
        end else begin
          step_d = (step_q == LAST_STEP) ? 3'd0 : step_q + 3'd1;
        end
      end

      ST_HALT: begin
        ctrl_w = C_HALTED;
        step_d = '0;
      end

      default: begin
        state_d = ST_PAUSE;
        step_d  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_PAUSE;
      step_q     <= '0;
      free_run_q <= 1'b0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      free_run_q <= free_run_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.ctrl       = ctrl_w;
  assign bus.step_count = step_q;
  assign bus.halted     = (state_q == ST_HALT);
  assign bus.busy       = (state_q == ST_EXEC);

endmodule

// File: tb/tb_sap1_sequencer.sv
// Self-checking bench for sap1_sequencer: directed vector table, hand-written corner
// sequences, and randomized stimulus against an instruction-level reference model.
module tb_sap1_sequencer;

  logic clk = 1'b0;
  logic reset;

  sap1_sequencer_if bus ();

  sap1_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          rst;
    bit          run;
    bit          stp;
    logic [3:0]  op;
    bit          z;
    bit          c;
    bit          chk;
    logic [15:0] ctrl;
    logic [2:0]  sc;
    bit          h;
    bit          b;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] ctrl, input logic [2:0] sc,
                            input bit h, input bit b);
    check({tag, ".ctrl"}, bus.ctrl, ctrl);
    check({tag, ".step_count"}, {13'd0, bus.step_count}, {13'd0, sc});
    check({tag, ".halted"}, {15'd0, bus.halted}, {15'd0, h});
    check({tag, ".busy"}, {15'd0, bus.busy}, {15'd0, b});
  endtask

  task automatic drive(input bit rst, input bit run, input bit stp, input logic [3:0] op,
                       input bit z, input bit c);
    reset         = rst;
    bus.run       = run;
    bus.step      = stp;
    bus.opcode    = op;
    bus.alu_zero  = z;
    bus.alu_carry = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One cycle: apply inputs, compare outputs of the current cycle, then clock.
  task automatic cyc(input string tag, input bit rst, input bit run, input bit stp,
                     input logic [3:0] op, input bit z, input bit c, input bit chk,
                     input logic [15:0] ctrl, input logic [2:0] sc, input bit h, input bit b);
    drive(rst, run, stp, op, z, c);
    if (chk) check_outs(tag, ctrl, sc, h, b);
    tick();
  endtask

  task automatic vec(input bit rst, input bit run, input bit stp, input logic [3:0] op,
                     input bit z, input bit c, input bit chk, input logic [15:0] ctrl,
                     input logic [2:0] sc, input bit h, input bit b);
    vec_t v;
    v.rst = rst; v.run = run; v.stp = stp; v.op = op; v.z = z; v.c = c;
    v.chk = chk; v.ctrl = ctrl; v.sc = sc; v.h = h; v.b = b;
    vecs.push_back(v);
  endtask

  // Reference model: an instruction is the fetch words followed by its execute words;
  // any micro-step past the end of that list reads as a bare micro_done.
  localparam int M_PAUSED = 0, M_RUNNING = 1, M_HALTED = 2;
  int m_mode, m_idx;
  bit m_free, m_c, m_z;

  function automatic logic [15:0] model_word(input int op, input int idx, input bit c, input bit z);
    logic [15:0] prog[$];
    prog.push_back(16'h0042);
    prog.push_back(16'h0824);
    case (op)
      1: begin prog.push_back(16'h0012); prog.push_back(16'h2404); end
      2: begin prog.push_back(16'h0012); prog.push_back(16'h0104); prog.push_back(16'h2401); end
      3: begin prog.push_back(16'h0012); prog.push_back(16'h0104); prog.push_back(16'h6401); end
      4: begin prog.push_back(16'h0012); prog.push_back(16'h2208); end
      5: prog.push_back(16'h2410);
      6: prog.push_back(16'h2090);
      7: prog.push_back(c ? 16'h2090 : 16'h2000);
      8: prog.push_back(z ? 16'h2090 : 16'h2000);
      14: prog.push_back(16'hA200);
      15: prog.push_back(16'h1000);
      default: prog.push_back(16'h2000);
    endcase
    return (idx < prog.size()) ? prog[idx] : 16'h2000;
  endfunction

  function automatic logic [15:0] model_ctrl(input int op);
    if (m_mode == M_PAUSED) return 16'h0000;
    if (m_mode == M_HALTED) return 16'h1000;
    return model_word(op, m_idx, m_c, m_z);
  endfunction

  task automatic model_edge(input bit rst, input bit run, input bit stp, input int op,
                            input bit z, input bit c);
    logic [15:0] w;
    if (rst) begin
      m_mode = M_PAUSED; m_idx = 0; m_free = 0; m_c = 0; m_z = 0;
      return;
    end
    if (m_mode == M_PAUSED) begin
      m_idx = 0;
      if (run) begin m_mode = M_RUNNING; m_free = 1; end
      else if (stp) begin m_mode = M_RUNNING; m_free = 0; end
    end else if (m_mode == M_RUNNING) begin
      w = model_word(op, m_idx, m_c, m_z);
      if (w[0]) begin m_c = c; m_z = z; end
      if (w == 16'h1000) begin
        m_mode = M_HALTED; m_idx = 0;
      end else if (w[13]) begin
        m_idx = 0;
        if (!(m_free && run)) m_mode = M_PAUSED;
      end else begin
        m_idx = (m_idx + 1) % 6;
      end
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);

    // Fetch / LDA, with run held through reset
    vec(1,1,0,4'h1,0,0, 0,16'h0000,3'd0,0,0);
    vec(0,1,0,4'h1,0,0, 1,16'h0000,3'd0,0,0);
    vec(0,1,0,4'h1,0,0, 1,16'h0042,3'd0,0,1);
    vec(0,1,0,4'h1,0,0, 1,16'h0824,3'd1,0,1);
    vec(0,1,0,4'h1,0,0, 1,16'h0012,3'd2,0,1);
    vec(0,1,0,4'h1,0,0, 1,16'h2404,3'd3,0,1);
    vec(0,1,0,4'h1,0,0, 1,16'h0042,3'd0,0,1);
    // SUB loads both flags, then JZ and JC are taken
    vec(0,1,0,4'h3,0,0, 1,16'h0824,3'd1,0,1);
    vec(0,1,0,4'h3,0,0, 1,16'h0012,3'd2,0,1);
    vec(0,1,0,4'h3,0,0, 1,16'h0104,3'd3,0,1);
    vec(0,1,0,4'h3,1,1, 1,16'h6401,3'd4,0,1);
    vec(0,1,0,4'h8,0,0, 1,16'h0042,3'd0,0,1);
    vec(0,1,0,4'h8,0,0, 1,16'h0824,3'd1,0,1);
    vec(0,1,0,4'h8,0,0, 1,16'h2090,3'd2,0,1);
    vec(0,1,0,4'h7,0,0, 1,16'h0042,3'd0,0,1);
    vec(0,1,0,4'h7,0,0, 1,16'h0824,3'd1,0,1);
    vec(0,1,0,4'h7,0,0, 1,16'h2090,3'd2,0,1);
    // Reset clears flags: JC and JZ fall through
    vec(1,1,0,4'h7,0,0, 0,16'h0000,3'd0,0,0);
    vec(0,1,0,4'h7,0,0, 1,16'h0000,3'd0,0,0);
    vec(0,1,0,4'h7,0,0, 1,16'h0042,3'd0,0,1);
    vec(0,1,0,4'h7,0,0, 1,16'h0824,3'd1,0,1);
    vec(0,1,0,4'h7,0,0, 1,16'h2000,3'd2,0,1);
    vec(0,1,0,4'h8,0,0, 1,16'h0042,3'd0,0,1);
    vec(0,1,0,4'h8,0,0, 1,16'h0824,3'd1,0,1);
    vec(0,0,0,4'h8,0,0, 1,16'h2000,3'd2,0,1);
    vec(0,0,0,4'h8,0,0, 1,16'h0000,3'd0,0,0);
    // Single step LDI; second pulse during EXEC is ignored
    vec(0,0,1,4'h5,0,0, 1,16'h0000,3'd0,0,0);
    vec(0,0,0,4'h5,0,0, 1,16'h0042,3'd0,0,1);
    vec(0,0,1,4'h5,0,0, 1,16'h0824,3'd1,0,1);
    vec(0,0,0,4'h5,0,0, 1,16'h2410,3'd2,0,1);
    vec(0,0,0,4'h5,0,0, 1,16'h0000,3'd0,0,0);
    vec(0,0,0,4'h5,0,0, 1,16'h0000,3'd0,0,0);

    foreach (vecs[i]) begin
      cyc($sformatf("vec%0d", i), vecs[i].rst, vecs[i].run, vecs[i].stp, vecs[i].op,
          vecs[i].z, vecs[i].c, vecs[i].chk, vecs[i].ctrl, vecs[i].sc, vecs[i].h, vecs[i].b);
    end

    // Halt: sticky under run and step, cleared only by reset
    cyc("hlt_rst", 1,0,0,4'hF,0,0, 0,16'h0000,3'd0,0,0);
    cyc("hlt_p",   0,1,0,4'hF,0,0, 1,16'h0000,3'd0,0,0);
    cyc("hlt_t0",  0,1,0,4'hF,0,0, 1,16'h0042,3'd0,0,1);
    cyc("hlt_t1",  0,1,0,4'hF,0,0, 1,16'h0824,3'd1,0,1);
    cyc("hlt_t2",  0,1,0,4'hF,0,0, 1,16'h1000,3'd2,0,1);
    for (int i = 0; i < 6; i++)
      cyc($sformatf("hlt_hold%0d", i), 0,1,i[0],4'hF,0,0, 1,16'h1000,3'd0,1,0);
    cyc("hlt_inrst", 1,0,0,4'hF,0,0, 1,16'h1000,3'd0,1,0);
    cyc("hlt_clr",   0,0,0,4'hF,0,0, 1,16'h0000,3'd0,0,0);

    // Mid-instruction: run drops at ADD T3, then reset at T3 of a second ADD
    cyc("mid_p",  0,1,0,4'h2,0,0, 1,16'h0000,3'd0,0,0);
    cyc("mid_t0", 0,1,0,4'h2,0,0, 1,16'h0042,3'd0,0,1);
    cyc("mid_t1", 0,1,0,4'h2,0,0, 1,16'h0824,3'd1,0,1);
    cyc("mid_t2", 0,1,0,4'h2,0,0, 1,16'h0012,3'd2,0,1);
    cyc("mid_t3", 0,0,0,4'h2,0,0, 1,16'h0104,3'd3,0,1);
    cyc("mid_t4", 0,0,0,4'h2,0,0, 1,16'h2401,3'd4,0,1);
    cyc("mid_ps", 0,1,0,4'h2,0,0, 1,16'h0000,3'd0,0,0);
    cyc("rst_t0", 0,1,0,4'h2,0,0, 1,16'h0042,3'd0,0,1);
    cyc("rst_t1", 0,1,0,4'h2,0,0, 1,16'h0824,3'd1,0,1);
    cyc("rst_t2", 0,1,0,4'h2,0,0, 1,16'h0012,3'd2,0,1);
    cyc("rst_t3", 1,1,0,4'h2,0,0, 1,16'h0104,3'd3,0,1);
    cyc("rst_aft",0,0,0,4'h2,0,0, 1,16'h0000,3'd0,0,0);

    // Randomized run against the reference model
    m_mode = M_PAUSED; m_idx = 0; m_free = 0; m_c = 0; m_z = 0;
    cyc("rnd_rst", 1,0,0,4'h0,0,0, 0,16'h0000,3'd0,0,0);
    for (int n = 0; n < 3000; n++) begin
      bit r_rst, r_run, r_stp, r_z, r_c;
      int r_op;
      int run_pct;
      run_pct = ((n / 500) % 2 == 0) ? 75 : 15;
      r_rst = ($urandom_range(0, 99) < 2);
      r_run = ($urandom_range(0, 99) < run_pct);
      r_stp = ($urandom_range(0, 99) < 20);
      r_z   = $urandom_range(0, 1) == 1;
      r_c   = $urandom_range(0, 1) == 1;
      r_op  = $urandom_range(0, 15);
      if (r_op == 15 && $urandom_range(0, 3) != 0) r_op = 0;
      drive(r_rst, r_run, r_stp, 4'(r_op), r_z, r_c);
      check_outs($sformatf("rnd%0d", n), model_ctrl(r_op), 3'(m_idx),
                 m_mode == M_HALTED, m_mode == M_RUNNING);
      tick();
      model_edge(r_rst, r_run, r_stp, r_op, r_z, r_c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sap1_sequencer.md
SAP1_SEQUENCER -- requirements
Module: sap1_sequencer

Interface
REQ-001 SHALL have the following ports, one per line (name  direction  width  meaning):
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; free-run enable.
- step  in  1  one-cycle pulse; execute exactly one instruction while paused.
- opcode  in  4  instruction register bits [7:4]; valid from T2 onward.
- alu_zero  in  1  ALU result == 0.
- alu_carry  in  1  ALU carry out.
- ctrl  out  16  control word, bits [15:0] = write_out, subtraction, micro_done, halted, inc_pc, write_a, read_a, write_b, write_pc, read_pc, write_instr, read_instr, write_mem, read_mem, write_mem_adr, read_alu.
- step_count  out  3  current micro-step T0..T5.
- halted  out  1  HALT state indicator.
- busy  out  1  high in EXEC.
REQ-002 SHALL have no parameters.

Function
REQ-010 SHALL implement three states: PAUSE, EXEC, HALT.
REQ-011 In PAUSE: ctrl=0x0000, step_count=0.
- run=1 -> EXEC, free-run mode.
- Else step=1 -> EXEC, single mode.
- run and step both high: run wins.
REQ-012 In EXEC, ctrl SHALL be combinational from (step_count, opcode, carry_flag, zero_flag) per REQ-013..015.
- step_count SHALL increment each cycle.
- A cycle with ctrl[13] (micro_done) set SHALL return step_count to 0 on the next edge.
REQ-013 Fetch, all opcodes: T0=0x0042, T1=0x0824.
REQ-014 Execute steps (T2 onward):
- NOP(0) and 9-D: T2=0x2000.
- LDA(1): T2=0x0012, T3=0x2404.
- ADD(2): T2=0x0012, T3=0x0104, T4=0x2401.
- SUB(3): T2=0x0012, T3=0x0104, T4=0x6401.
- STA(4): T2=0x0012, T3=0x2208.
- LDI(5): T2=0x2410.
- JMP(6): T2=0x2090.
- JC(7): T2=0x2090 if carry_flag, else 0x2000.
- JZ(8): T2=0x2090 if zero_flag, else 0x2000.
- OUT(E): T2=0xA200.
- HLT(F): T2=0x1000.
REQ-015 Any (opcode, step) not listed SHALL produce 0x2000; step_count SHALL wrap 5->0 if micro_done is never asserted.
REQ-016 At micro_done, the next state SHALL be:
- EXEC at T0 if free-run mode and run=1.
- Otherwise PAUSE. Covers single mode, and run dropping mid-instruction: the instruction completes, never aborted.
REQ-017 step pulses during EXEC or HALT SHALL be ignored.
REQ-018 HLT at T2 SHALL enter HALT on the next edge.
- HALT: ctrl=0x1000, halted=1, step_count=0, busy=0.
- Exit only by reset.
REQ-019 Internal carry_flag/zero_flag:
- Load alu_carry/alu_zero on each edge where state=EXEC and ctrl[0]=1.
- Otherwise hold.
REQ-020 halted SHALL be registered state decode.
REQ-021 busy SHALL equal (state==EXEC).

Reset
REQ-030 reset SHALL override all other inputs, including mid-instruction and in HALT.
REQ-031 One reset edge SHALL give: state=PAUSE, step_count=0, flags=0, ctrl=0x0000, halted=0, busy=0.
REQ-032 With run=1 held through reset, EXEC T0 SHALL begin on the first edge after reset deasserts.

Verification
REQ-040 Bench SHALL cover:
- Fetch/LDA: reset, run=1, opcode=1 -> ctrl 0x0042, 0x0824, 0x0012, 0x2404, then 0x0042 again (step_count 0,1,2,3,0).
- SUB and flag: opcode=3, alu_zero=1, alu_carry=1 at T4 -> ctrl T4=0x6401; then opcode=8 -> T2=0x2090; then opcode=7 -> T2=0x2090.
- Flags clear: after reset, opcode=7 -> T2=0x2000; opcode=8 -> T2=0x2000.
- Single step: run=0, one step pulse, opcode=5 -> ctrl 0x0042, 0x0824, 0x2410, then PAUSE with ctrl=0x0000; a second step pulse issued during EXEC has no effect.
- Halt: opcode=F in free-run -> T2=0x1000, then halted=1 indefinitely with run=1 and step pulses applied; reset -> halted=0, ctrl=0x0000.
- Mid-instruction: run drops at T3 of ADD -> T4=0x2401, then PAUSE; reset asserted at T3 of a second ADD -> step_count=0, ctrl=0x0000 next cycle.
